// File: rtl/apple1_uart_tx.sv
// Apple-1 display-port UART transmitter: CPU writes at 0xD012 are queued and sent as 8N1 on uart_tx.
// Optional build macro APPLE1_UART_TX_CRLF_EN expands CR into a CR/LF pair.
module apple1_uart_tx #(
  parameter int CLK_HZ     = 14000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk14,
  input  logic       rst,
  input  logic       enable,
  input  logic       cs,
  input  logic       w_en,
  input  logic       address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       uart_tx
);

  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(BAUD_DIV - 1);
`ifdef APPLE1_UART_TX_CRLF_EN
  // One slot held back so a CR/LF pair is never split.
  localparam logic [4:0] FULL_AT = 5'(FIFO_DEPTH - 1);
`else
  localparam logic [4:0] FULL_AT = 5'(FIFO_DEPTH);
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [4:0]       count;
  logic             overflow;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             pop;

  logic             full, empty, tx_active;
  logic             wr_data, wr_status, push, is_cr;
  logic [7:0]       wr_byte, head;
  logic [1:0]       n_push;

  assign full      = (count >= FULL_AT);
  assign empty     = (count == 5'd0);
  assign tx_active = (state != IDLE);
  assign wr_data   = cs & w_en & enable & ~address;
  assign wr_status = cs & w_en & enable & address;
  assign wr_byte   = din & 8'h7F;
  assign push      = wr_data & ~full;
  assign head      = mem[rd_ptr];
`ifdef APPLE1_UART_TX_CRLF_EN
  assign is_cr     = (wr_byte == 8'h0D);
`else
  assign is_cr     = 1'b0;
`endif
  assign n_push    = push ? (is_cr ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge clk14) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + 5'(n_push) - 5'(pop);
      // Drop decision uses the pre-edge fill level, even if a pop lands on the same edge.
      if (wr_data && full) overflow <= 1'b1;
      else if (wr_status)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk14) begin
    if (push) begin
      mem[wr_ptr] <= wr_byte;
`ifdef APPLE1_UART_TX_CRLF_EN
      if (is_cr) mem[wr_ptr + AW'(1)] <= 8'h0A;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = uart_tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_n    = head;
          baud_cnt_n = DIV_M1;
          tx_n       = 1'b0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          tx_n       = shreg[0];
          shreg_n    = {1'b0, shreg[7:1]};
          bit_idx_n  = 3'd0;
          baud_cnt_n = DIV_M1;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = DIV_M1;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          // Chain straight into the next start bit so queued frames are contiguous.
          if (!empty) begin
            pop        = 1'b1;
            shreg_n    = head;
            baud_cnt_n = DIV_M1;
            tx_n       = 1'b0;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk14) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      uart_tx  <= tx_n;
    end
  end

  always_ff @(posedge clk14) begin
    shreg <= shreg_n;
  end

  always_comb begin
    if (address) dout = {tx_active, empty, overflow, count};
    else         dout = {full, 7'b0};
  end

endmodule
